// File: rtl/inport_buffer_pkg.sv
// Shared constants for the input-port buffer and the datapath bus mux.
// DATA_WIDTH is the bus width seen by every bus source.
package inport_buffer_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int DEPTH      = 4;
    localparam int AW         = $clog2(DEPTH);

endpackage

// File: rtl/inport_buffer_sync.sv
// Small synchronous FIFO: storage, wrapping pointers and occupancy count.
// push/pop arrive already qualified against full/empty by the caller.
module sync_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage write; contents need no reset since count guards reads.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);

endmodule

// File: rtl/inport_buffer.sv
// Input-port stage: buffers device words, hands one word to the bus per
// inport_select assertion, and reports sticky overflow/underflow.
module inport_buffer
    import inport_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = inport_buffer_pkg::DATA_WIDTH,
    parameter int DEPTH      = inport_buffer_pkg::DEPTH,
    parameter int AW         = inport_buffer_pkg::AW
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] ext_data,
    input  logic                  ext_valid,
    output logic                  ext_ready,
    input  logic                  inport_select,
    output logic [DATA_WIDTH-1:0] inport_Data,
    output logic                  inport_empty,
    output logic [AW:0]           inport_count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  flag_clear
);

    logic                  sel_d;
    logic [DATA_WIDTH-1:0] last_word;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  full;
    logic                  empty;
    logic                  pop_req;
    logic                  push;
    logic                  pop;
    logic                  ovf_evt;
    logic                  unf_evt;

    // Ready is plain !full: a same-cycle pop never opens room for a push.
    assign pop_req = sel_d && !inport_select;
    assign push    = ext_valid && !full;
    assign pop     = pop_req && !empty;
    assign ovf_evt = ext_valid && full;
    assign unf_evt = pop_req && empty;

    sync_fifo #(
        .DW    (DATA_WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (ext_data),
        .dout  (fifo_dout),
        .count (inport_count),
        .full  (full),
        .empty (empty)
    );

    // Select edge detector and copy of the most recently consumed word.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_d     <= 1'b0;
            last_word <= '0;
        end else begin
            sel_d <= inport_select;
            if (pop) last_word <= fifo_dout;
        end
    end

    // Sticky error flags; a fresh event beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (overflow  && !flag_clear) || ovf_evt;
            underflow <= (underflow && !flag_clear) || unf_evt;
        end
    end

    // Empty buffer keeps showing the last consumed word so the bus is stable.
    assign inport_Data  = empty ? last_word : fifo_dout;
    assign ext_ready    = !full;
    assign inport_empty = empty;

endmodule

// File: tb/tb_inport_buffer.sv
// Directed bench for inport_buffer with a scoreboard queue of
// expected consumed words checked by an independent monitor.
module tb_inport_buffer;

    localparam int DW = 32;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] ext_data;
    logic          ext_valid;
    logic          ext_ready;
    logic          inport_select;
    logic [DW-1:0] inport_Data;
    logic          inport_empty;
    logic [AW:0]   inport_count;
    logic          overflow;
    logic          underflow;
    logic          flag_clear;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] exp_q [$];
    logic          sel_prev = 1'b0;

    inport_buffer dut (
        .clk           (clk),
        .reset         (reset),
        .ext_data      (ext_data),
        .ext_valid     (ext_valid),
        .ext_ready     (ext_ready),
        .inport_select (inport_select),
        .inport_Data   (inport_Data),
        .inport_empty  (inport_empty),
        .inport_count  (inport_count),
        .overflow      (overflow),
        .underflow     (underflow),
        .flag_clear    (flag_clear)
    );

    always #5 clk = ~clk;

    // Independent model of the registered select.
    always @(posedge clk) sel_prev <= reset ? 1'b0 : inport_select;

    // Monitor: a word is consumed at the coming edge; compare it now.
    always @(negedge clk) begin
        if (!reset && sel_prev && !inport_select && exp_q.size() > 0) begin
            logic [DW-1:0] e;
            e = exp_q.pop_front();
            n_checks++;
            if (inport_Data !== e) begin
                n_fail++;
                $display("FAIL pop_data: got %h expected %h", inport_Data, e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] d, input bit accepted);
        ext_data  = d;
        ext_valid = 1'b1;
        if (accepted) exp_q.push_back(d);
        tick();
        ext_valid = 1'b0;
    endtask

    task automatic pop_pulse();
        inport_select = 1'b1;
        tick();
        inport_select = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        ext_data = '0;
        ext_valid = 1'b0;
        inport_select = 1'b0;
        flag_clear = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // 1: reset state
        chk("rst_ready", 32'(ext_ready), 32'd1);
        chk("rst_empty", 32'(inport_empty), 32'd1);
        chk("rst_data", inport_Data, 32'h0);
        chk("rst_count", 32'(inport_count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_unf", 32'(underflow), 32'd0);

        // 2: one pop per long select
        push_word(32'h11, 1'b1);
        chk("first_visible", inport_Data, 32'h11);
        push_word(32'h22, 1'b1);
        inport_select = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_data", inport_Data, 32'h11);
        end
        inport_select = 1'b0;
        tick();
        chk("after_rel_data", inport_Data, 32'h22);
        chk("after_rel_count", 32'(inport_count), 32'd1);
        pop_pulse();
        chk("drained_count", 32'(inport_count), 32'd0);
        chk("last_word", inport_Data, 32'h22);

        // 4: underflow keeps last word
        inport_select = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("unf_hold_data", inport_Data, 32'h22);
        end
        inport_select = 1'b0;
        tick();
        chk("unf_flag", 32'(underflow), 32'd1);
        chk("unf_data", inport_Data, 32'h22);
        chk("unf_count", 32'(inport_count), 32'd0);
        flag_clear = 1'b1;
        tick();
        flag_clear = 1'b0;
        chk("unf_clear", 32'(underflow), 32'd0);

        // 3: fill, overflow, clear
        for (int i = 0; i < 4; i++) push_word(32'hA0 + 32'(i), 1'b1);
        chk("full_ready", 32'(ext_ready), 32'd0);
        chk("full_count", 32'(inport_count), 32'd4);
        push_word(32'hA4, 1'b0);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(inport_count), 32'd4);
        chk("ovf_head", inport_Data, 32'hA0);
        flag_clear = 1'b1;
        push_word(32'hA5, 1'b0);
        chk("ovf_set_wins", 32'(overflow), 32'd1);
        tick();
        flag_clear = 1'b0;
        chk("ovf_clear", 32'(overflow), 32'd0);
        pop_pulse();
        pop_pulse();
        chk("two_left", 32'(inport_count), 32'd2);

        // 5: simultaneous push and pop, then wrap
        inport_select = 1'b1;
        tick();
        inport_select = 1'b0;
        push_word(32'hB1, 1'b1);
        chk("pushpop_count", 32'(inport_count), 32'd2);
        for (int i = 0; i < 8; i++) begin
            inport_select = 1'b1;
            tick();
            inport_select = 1'b0;
            push_word(32'hC0 + 32'(i), 1'b1);
        end
        chk("wrap_count", 32'(inport_count), 32'd2);
        chk("wrap_head", inport_Data, 32'hC6);
        push_word(32'hD0, 1'b1);
        chk("pre_rst_count", 32'(inport_count), 32'd3);

        // 6: reset during select
        inport_select = 1'b1;
        tick();
        reset = 1'b1;
        exp_q.delete();
        tick();
        reset = 1'b0;
        chk("r6_count", 32'(inport_count), 32'd0);
        chk("r6_data", inport_Data, 32'h0);
        chk("r6_ovf", 32'(overflow), 32'd0);
        chk("r6_unf", 32'(underflow), 32'd0);
        chk("r6_ready", 32'(ext_ready), 32'd1);
        tick();
        inport_select = 1'b0;
        tick();
        chk("r6_post_unf", 32'(underflow), 32'd1);
        chk("r6_post_count", 32'(inport_count), 32'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
